// File: rtl/wb_pkg.sv
// Shared types for the register-file write-back arbiter.
// Request bundle, arbiter state and default widths.
package wb_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    typedef enum logic {
        NORMAL = 1'b0,
        FORCE  = 1'b1
    } wb_state_t;

endpackage

// File: rtl/wb_write_arbiter_if.sv
// ALU / LSU request channels and the registered register-file write port.
// master drives requests, slave is the arbiter.
interface wb_write_arbiter_if #(
    parameter int DATA_W = wb_pkg::DATA_W,
    parameter int ADDR_W = wb_pkg::ADDR_W
);

    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_addr;
    logic [DATA_W-1:0] alu_data;

    logic              lsu_valid;
    logic              lsu_ready;
    logic [ADDR_W-1:0] lsu_addr;
    logic [DATA_W-1:0] lsu_data;

    logic              rf_we;
    logic [ADDR_W-1:0] rf_addr;
    logic [DATA_W-1:0] rf_data;

    modport master (
        output alu_valid, alu_addr, alu_data,
        output lsu_valid, lsu_addr, lsu_data,
        input  alu_ready, lsu_ready,
        input  rf_we, rf_addr, rf_data
    );

    modport slave (
        input  alu_valid, alu_addr, alu_data,
        input  lsu_valid, lsu_addr, lsu_data,
        output alu_ready, lsu_ready,
        output rf_we, rf_addr, rf_data
    );

endinterface

// File: rtl/wb_fifo.sv
// Synchronous FIFO of write-back requests with occupancy count
// and a per-entry valid/address view for the pending-write check.
module wb_fifo
    import wb_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  wb_req_t                       wdata,
    input  logic                          pop,
    output wb_req_t                       rdata,
    output logic                          full,
    output logic                          empty,
    output logic [CW-1:0]                 count,
    output logic [DEPTH-1:0]              ent_valid,
    output logic [DEPTH-1:0][ADDR_W-1:0]  ent_addr
);

    wb_req_t         mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Entry i is live when its distance from the read pointer is below count.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_valid[i] = {1'b0, PW'(PW'(i) - rd_ptr)} < count;
            ent_addr[i]  = mem[i].addr;
        end
    end

endmodule

// File: rtl/wb_write_arbiter.sv
// Register-file write-back arbiter: ALU has priority, LSU is buffered.
// WB_BYPASS_EN lets an LSU write skip the empty FIFO when the port is idle.
module wb_write_arbiter
#(
    parameter  int DATA_W       = wb_pkg::DATA_W,
    parameter  int ADDR_W       = wb_pkg::ADDR_W,
    parameter  int FIFO_DEPTH   = 4,
    parameter  int STARVE_LIMIT = 3,
    localparam int CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    wb_write_arbiter_if.slave bus,
    input  logic [ADDR_W-1:0] chk_addr,
    output logic              chk_pending,
    output logic [CNT_W-1:0]  fifo_count
);

    import wb_pkg::*;

    localparam int SC_W = $clog2(STARVE_LIMIT + 1);

    wb_state_t                       state;
    wb_state_t                       state_nxt;
    logic [SC_W-1:0]                 starve_cnt;
    logic                            full;
    logic                            empty;
    logic                            push;
    logic                            pop;
    logic                            byp;
    logic                            alu_wr;
    logic                            lsu_wr;
    logic                            starved;
    logic                            hit;
    logic                            wr_en;
    logic [ADDR_W-1:0]               wr_addr;
    logic [DATA_W-1:0]               wr_data;
    wb_req_t                         head;
    wb_req_t                         lsu_req;
    logic [FIFO_DEPTH-1:0]           ent_valid;
    logic [FIFO_DEPTH-1:0][ADDR_W-1:0] ent_addr;

    assign alu_wr        = bus.alu_valid && bus.alu_ready && (bus.alu_addr != '0);
    assign lsu_wr        = bus.lsu_valid && bus.lsu_ready && (bus.lsu_addr != '0);
    assign bus.lsu_ready = !full;
    assign push          = lsu_wr && !byp;
    assign lsu_req.addr  = bus.lsu_addr;
    assign lsu_req.data  = bus.lsu_data;

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .wdata     (lsu_req),
        .pop       (pop),
        .rdata     (head),
        .full      (full),
        .empty     (empty),
        .count     (fifo_count),
        .ent_valid (ent_valid),
        .ent_addr  (ent_addr)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= NORMAL;
        else       state <= state_nxt;
    end

    assign starved = (state == NORMAL) && !empty && !pop &&
                     (starve_cnt == SC_W'(STARVE_LIMIT - 1));

    always_comb begin
        state_nxt = state;
        unique case (state)
            NORMAL:  if (starved) state_nxt = FORCE;
            FORCE:   state_nxt = NORMAL;
            default: state_nxt = NORMAL;
        endcase
    end

    // In NORMAL alu_ready is 1, so alu_valid alone means an ALU transfer.
    always_comb begin
        bus.alu_ready = 1'b1;
        pop           = 1'b0;
        byp           = 1'b0;
        unique case (state)
            NORMAL: begin
                pop = !empty && !bus.alu_valid;
`ifdef WB_BYPASS_EN
                byp = lsu_wr && empty && !bus.alu_valid;
`endif
            end
            FORCE: begin
                bus.alu_ready = 1'b0;
                pop           = !empty;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                      starve_cnt <= '0;
        else if (state == FORCE || pop) starve_cnt <= '0;
        else if (!empty)                starve_cnt <= starve_cnt + 1'b1;
    end

    always_comb begin
        wr_en   = alu_wr || pop || byp;
        wr_addr = head.addr;
        wr_data = head.data;
        unique case (1'b1)
            alu_wr: begin
                wr_addr = bus.alu_addr;
                wr_data = bus.alu_data;
            end
            byp: begin
                wr_addr = bus.lsu_addr;
                wr_data = bus.lsu_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.rf_we   <= 1'b0;
            bus.rf_addr <= '0;
            bus.rf_data <= '0;
        end else begin
            bus.rf_we <= wr_en;
            if (wr_en) begin
                bus.rf_addr <= wr_addr;
                bus.rf_data <= wr_data;
            end
        end
    end

    always_comb begin
        hit = bus.rf_we && (bus.rf_addr == chk_addr);
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (ent_valid[i] && (ent_addr[i] == chk_addr)) hit = 1'b1;
        end
    end

    assign chk_pending = (chk_addr != '0) && hit;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Bench for wb_write_arbiter: cycle vector table, directed corner
// sequences and a write scoreboard fed from accepted requests.
module tb_wb_write_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] chk_addr;
    logic       chk_pending;
    logic [2:0] fifo_count;
    int         errors = 0;
    int         checks = 0;

    wb_write_arbiter_if bus ();

    wb_write_arbiter #(
        .FIFO_DEPTH   (4),
        .STARVE_LIMIT (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .chk_addr    (chk_addr),
        .chk_pending (chk_pending),
        .fifo_count  (fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    typedef struct {
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        lv;
        logic [4:0]  la;
        logic [31:0] ld;
        logic [4:0]  ca;
        logic        ar;
        logic        lr;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [2:0]  cnt;
        logic        pd;
    } vec_t;

    vec_t vt [16];
    wr_t  lsu_q [$];
    logic alu_pend = 1'b0;
    wr_t  alu_exp;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t v(int av, int aa, int ad, int lv, int la,
                               int ld, int ca, int ar, int lr, int we,
                               int wa, int wd, int cnt, int pd);
        vec_t r;
        r.av = 1'(av);  r.aa = 5'(aa);  r.ad = 32'(ad);
        r.lv = 1'(lv);  r.la = 5'(la);  r.ld = 32'(ld);
        r.ca = 5'(ca);  r.ar = 1'(ar);  r.lr = 1'(lr);
        r.we = 1'(we);  r.wa = 5'(wa);  r.wd = 32'(wd);
        r.cnt = 3'(cnt); r.pd = 1'(pd);
        return r;
    endfunction

    task automatic drive(input logic av, input logic [4:0] aa,
                         input logic [31:0] ad, input logic lv,
                         input logic [4:0] la, input logic [31:0] ld,
                         input logic [4:0] ca);
        bus.alu_valid = av;
        bus.alu_addr  = aa;
        bus.alu_data  = ad;
        bus.lsu_valid = lv;
        bus.lsu_addr  = la;
        bus.lsu_data  = ld;
        chk_addr      = ca;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: ALU writes must land exactly one cycle later,
    // LSU writes must appear in acceptance order.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                lsu_q.delete();
                alu_pend = 1'b0;
            end else begin
                if (alu_pend) begin
                    chk("sb alu_we", 64'(bus.rf_we), 64'd1);
                    chk("sb alu_write", 64'({bus.rf_addr, bus.rf_data}),
                        64'(alu_exp));
                end else if (bus.rf_we) begin
                    if (lsu_q.size() == 0) begin
                        chk("sb unexpected_we", 64'(bus.rf_we), 64'd0);
                    end else begin
                        chk("sb lsu_write", 64'({bus.rf_addr, bus.rf_data}),
                            64'(lsu_q[0]));
                        lsu_q.delete(0);
                    end
                end
                alu_pend = bus.alu_valid && bus.alu_ready &&
                           (bus.alu_addr != 5'd0);
                alu_exp  = {bus.alu_addr, bus.alu_data};
                if (bus.lsu_valid && bus.lsu_ready && bus.lsu_addr != 5'd0)
                    lsu_q.push_back({bus.lsu_addr, bus.lsu_data});
            end
        end
    end

    initial begin
        vt[0]  = v(0,  0, 'h00,   0,  0, 'h000,  0, 1,1,0,  0, 'h00,  0,0);
        vt[1]  = v(1,  5, 'h11,   0,  0, 'h000,  5, 1,1,0,  0, 'h00,  0,0);
        vt[2]  = v(1,  6, 'h22,   0,  0, 'h000,  5, 1,1,1,  5, 'h11,  0,1);
        vt[3]  = v(1,  7, 'h33,   1,  9, 'h090,  9, 1,1,1,  6, 'h22,  0,0);
        vt[4]  = v(1,  8, 'h44,   1, 10, 'h0a0,  9, 1,1,1,  7, 'h33,  1,1);
        vt[5]  = v(1, 11, 'h55,   1, 12, 'h0c0,  9, 1,1,1,  8, 'h44,  2,1);
        vt[6]  = v(1, 13, 'h66,   1, 14, 'h0e0, 10, 1,1,1, 11, 'h55,  3,1);
        vt[7]  = v(1, 15, 'h77,   1, 16, 'h100,  9, 0,0,1, 13, 'h66,  4,1);
        vt[8]  = v(1, 15, 'h77,   1, 16, 'h100,  9, 1,1,1,  9, 'h90,  3,1);
        vt[9]  = v(0,  0, 'h00,   0,  0, 'h000,  9, 1,0,1, 15, 'h77,  4,0);
        vt[10] = v(1,  0, 'hdead, 1,  0, 'hdead, 0, 1,1,1, 10, 'ha0,  3,0);
        vt[11] = v(0,  0, 'h00,   0,  0, 'h000, 12, 1,1,0,  0, 'h00,  3,1);
        vt[12] = v(0,  0, 'h00,   0,  0, 'h000, 12, 1,1,1, 12, 'hc0,  2,1);
        vt[13] = v(0,  0, 'h00,   0,  0, 'h000, 12, 1,1,1, 14, 'he0,  1,0);
        vt[14] = v(0,  0, 'h00,   0,  0, 'h000,  0, 1,1,1, 16, 'h100, 0,0);
        vt[15] = v(0,  0, 'h00,   0,  0, 'h000,  0, 1,1,0,  0, 'h00,  0,0);

        reset = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset rf_we", 64'(bus.rf_we), 64'd0);
        chk("reset rf_addr", 64'(bus.rf_addr), 64'd0);
        chk("reset rf_data", 64'(bus.rf_data), 64'd0);
        chk("reset fifo_count", 64'(fifo_count), 64'd0);
        chk("reset alu_ready", 64'(bus.alu_ready), 64'd1);
        chk("reset lsu_ready", 64'(bus.lsu_ready), 64'd1);
        next_cycle();
        reset = 1'b0;

        for (int k = 0; k < 16; k++) begin
            drive(vt[k].av, vt[k].aa, vt[k].ad, vt[k].lv,
                  vt[k].la, vt[k].ld, vt[k].ca);
            @(negedge clk);
            chk($sformatf("v%0d alu_ready", k), 64'(bus.alu_ready), 64'(vt[k].ar));
            chk($sformatf("v%0d lsu_ready", k), 64'(bus.lsu_ready), 64'(vt[k].lr));
            chk($sformatf("v%0d rf_we", k), 64'(bus.rf_we), 64'(vt[k].we));
            chk($sformatf("v%0d fifo_count", k), 64'(fifo_count), 64'(vt[k].cnt));
            chk($sformatf("v%0d chk_pending", k), 64'(chk_pending), 64'(vt[k].pd));
            if (vt[k].we) begin
                chk($sformatf("v%0d rf_addr", k), 64'(bus.rf_addr), 64'(vt[k].wa));
                chk($sformatf("v%0d rf_data", k), 64'(bus.rf_data), 64'(vt[k].wd));
            end
            next_cycle();
        end

        // LSU latency from an idle port.
        idle();
        repeat (2) next_cycle();
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h7, 5'd3);
        @(negedge clk);
        chk("lat pending_before", 64'(chk_pending), 64'd0);
        next_cycle();
        idle();
        chk_addr = 5'd3;
        @(negedge clk);
        chk("lat1 pending", 64'(chk_pending), 64'd1);
`ifdef WB_BYPASS_EN
        chk("lat1 rf_we", 64'(bus.rf_we), 64'd1);
        chk("lat1 rf_write", 64'({bus.rf_addr, bus.rf_data}), 64'({5'd3, 32'h7}));
        chk("lat1 fifo_count", 64'(fifo_count), 64'd0);
        next_cycle();
        @(negedge clk);
        chk("lat2 rf_we", 64'(bus.rf_we), 64'd0);
        chk("lat2 fifo_count", 64'(fifo_count), 64'd0);
`else
        chk("lat1 rf_we", 64'(bus.rf_we), 64'd0);
        chk("lat1 fifo_count", 64'(fifo_count), 64'd1);
        next_cycle();
        @(negedge clk);
        chk("lat2 rf_we", 64'(bus.rf_we), 64'd1);
        chk("lat2 rf_write", 64'({bus.rf_addr, bus.rf_data}), 64'({5'd3, 32'h7}));
        chk("lat2 fifo_count", 64'(fifo_count), 64'd0);
`endif
        next_cycle();

        // Reset with three LSU entries queued behind ALU traffic.
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 5'(k + 1), 32'(k + 'h100), 1'b1, 5'(k + 20),
                  32'(k + 'h200), 5'd0);
            next_cycle();
        end
        idle();
        chk("rq count_before", 64'(fifo_count), 64'd3);
        reset = 1'b1;
        #1;
        chk("rq count_reset", 64'(fifo_count), 64'd0);
        chk("rq rf_we_reset", 64'(bus.rf_we), 64'd0);
        repeat (2) next_cycle();
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("rq%0d rf_we", k), 64'(bus.rf_we), 64'd0);
            chk($sformatf("rq%0d count", k), 64'(fifo_count), 64'd0);
            next_cycle();
        end

        // Random traffic checked by the scoreboard.
        for (int k = 0; k < 300; k++) begin
            drive(1'($urandom_range(0, 9) < 7), 5'($urandom_range(0, 31)),
                  $urandom, 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 31)), $urandom,
                  5'($urandom_range(0, 31)));
            next_cycle();
        end
        idle();
        repeat (10) next_cycle();
        @(negedge clk);
        chk("drain lsu_q_empty", 64'(lsu_q.size()), 64'd0);
        chk("drain fifo_count", 64'(fifo_count), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_write_arbiter.md
# wb_write_arbiter

Write-back arbiter for the single write port of the 32x32 CPU register file. Merges a high-priority ALU result stream and a buffered, lower-priority load/multi-cycle (LSU) result stream into one registered write each cycle. Provides a pending-write check so operand fetch can detect hazards on registers with queued writes. Sits between the execute/memory stages and the register file write port; the register file commits on the falling edge of the cycle in which `rf_we` is high.

## Interface
- DATA_W, 32, write data width
- ADDR_W, 5, register address width
- FIFO_DEPTH, 4, LSU buffer entries (power of two, >=2)
- STARVE_LIMIT, 3, consecutive cycles LSU head may be blocked before forced service
---
- clk  in  1  rising-edge clock
- reset  in  1  reset, asynchronous, active-high
- alu_valid  in  1  ALU write request
- alu_ready  out  1  ALU request accepted this cycle
- alu_addr  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- lsu_valid  in  1  LSU write request
- lsu_ready  out  1  LSU request accepted (= FIFO not full)
- lsu_addr  in  ADDR_W  LSU destination register
- lsu_data  in  DATA_W  LSU result
- rf_we  out  1  register file write enable (registered)
- rf_addr  out  ADDR_W  register file write address (registered)
- rf_data  out  DATA_W  register file write data (registered)
- chk_addr  in  ADDR_W  register address to test
- chk_pending  out  1  write to chk_addr queued or in output stage
- fifo_count  out  log2(FIFO_DEPTH)+1  LSU entries held

## Operation
- Handshake: transfer when valid && ready at rising edge; requests to register 0 are accepted and discarded (never enqueued, never written).
- Two states: NORMAL and FORCE.
- NORMAL: alu_ready=1. ALU transfer wins the output stage; otherwise the FIFO head pops into the output stage. If neither, rf_we=0 next cycle.
- starve_cnt increments each NORMAL cycle where FIFO is non-empty and the head is not popped; clears on any pop. Reaching STARVE_LIMIT moves to FORCE.
- FORCE: alu_ready=0, head pops unconditionally, starve_cnt clears, returns to NORMAL next cycle. Lasts exactly one cycle.
- FIFO: lsu_ready = !full; no same-cycle push-through when full, even with a concurrent pop. Simultaneous push and pop when non-full leaves count unchanged.
- chk_pending: combinational OR of (chk_addr!=0) && match against every valid FIFO entry and the output stage when rf_we=1.
- No ordering between ALU and LSU writes to the same register; the pipeline uses chk_pending to avoid write-after-write hazards.
- Reset: rf_we=0, rf_addr=0, rf_data=0, FIFO empty, fifo_count=0, starve_cnt=0, state NORMAL. lsu_ready=1 and alu_ready=1 combinationally, but no transfer is taken while reset is high. Reset mid-operation discards all queued writes.

## Timing
- ALU latency 1: accepted at edge N, rf_we high during cycle N+1.
- LSU latency >=2: pushed at edge N, earliest pop at edge N+1, rf_we in cycle N+2.
- Worst-case LSU head wait: STARVE_LIMIT+1 cycles after reaching the head.
- chk_pending and alu_ready/lsu_ready are combinational from current state; all other outputs are registered.

## Configuration
- WB_BYPASS_EN defined: an LSU transfer when the FIFO is empty, no ALU transfer occurs, and state is NORMAL goes straight to the output stage, giving latency 1. The transfer is not enqueued.
- Undefined: every LSU write passes through the FIFO.

## Structure
- Package wb_pkg: DATA_W/ADDR_W defaults, wb_req_t {addr, data}, state enum {NORMAL, FORCE}.
- Sub-module wb_fifo: synchronous FIFO of wb_req_t with count, full/empty, and a per-entry valid/addr view for chk_pending.

## Test plan
- ALU stream: alu writes r5=0x11, r6=0x22 on consecutive cycles -> rf_we/rf_addr/rf_data show 5/0x11 then 6/0x22, each one cycle after acceptance.
- LSU fill: 5 LSU pushes with ALU busy every cycle -> lsu_ready drops after 4, fifo_count=4. FORCE occurs after 3 blocked cycles with alu_ready=0 for one cycle, and the head is written.
- r0 drop: ALU and LSU writes to r0 with data 0xDEAD -> accepted, rf_we stays 0, fifo_count unchanged.
- Pending check: LSU write to r9 queued behind ALU traffic -> chk_pending=1 for chk_addr=9 until the cycle after rf_we for r9 ends; chk_addr=0 -> always 0.
- Reset mid-queue: 3 entries queued, assert reset -> fifo_count=0, rf_we=0 immediately, and no queued write appears after release.
- WB_BYPASS_EN: idle, LSU writes r3=0x7 -> rf_we in the next cycle, fifo_count stays 0. Without the macro -> two cycles, fifo_count shows 1.
